// File: rtl/sprite_dispatcher_if.sv
// Bus bundle between the request/table/blitter side and sprite_dispatcher.
// master: drives requests, acks, table data and blitter_finished.
// slave:  the dispatcher itself.
interface sprite_dispatcher_if #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 6,
  parameter int ADDR_W = 25,
  parameter int SIZE_W = 10
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]          sprite_incoming;
  logic [NUM_CH*IDX_W-1:0]    sprite_num;
  logic [NUM_CH-1:0]          acknowledge_finished_sprite;
  logic [NUM_CH-1:0]          sprite_received;
  logic [NUM_CH-1:0]          sprite_finished;
  logic [IDX_W-1:0]           table_index;
  logic [ADDR_W+2*SIZE_W-1:0] table_data;
  logic                       blitter_start;
  logic                       blitter_finished;
  logic [ADDR_W-1:0]          sprite_address;
  logic [SIZE_W-1:0]          x_size;
  logic [SIZE_W-1:0]          y_size;
  logic [CH_W-1:0]            active_ch;
  logic                       busy;
  logic                       blit_error;

  modport master (
    output sprite_incoming, sprite_num, acknowledge_finished_sprite,
           table_data, blitter_finished,
    input  sprite_received, sprite_finished, table_index, blitter_start,
           sprite_address, x_size, y_size, active_ch, busy, blit_error
  );

  modport slave (
    input  sprite_incoming, sprite_num, acknowledge_finished_sprite,
           table_data, blitter_finished,
    output sprite_received, sprite_finished, table_index, blitter_start,
           sprite_address, x_size, y_size, active_ch, busy, blit_error
  );
endinterface

// File: rtl/sprite_dispatcher.sv
// sprite_dispatcher: round-robin arbiter over NUM_CH sprite requesters.
// Each granted request looks up address/size in a synchronous sprite table,
// starts the blitter and runs the received/finished/ack handshake with the
// owning channel. Optional watchdog on the blit phase: define WATCHDOG_EN.
module sprite_dispatcher #(
  parameter int NUM_CH         = 4,
  parameter int IDX_W          = 6,
  parameter int ADDR_W         = 25,
  parameter int SIZE_W         = 10,
  parameter int TABLE_LAT      = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic Clk,
  input logic Reset,
  sprite_dispatcher_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LAT_W = $clog2(TABLE_LAT + 1);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(TABLE_LAT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_START, S_RELEASE, S_BLIT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    active_ch_q, active_ch_d;
  logic [CH_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   table_index_q, table_index_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [SIZE_W-1:0]  xs_q, xs_d;
  logic [SIZE_W-1:0]  ys_q, ys_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic               done_q, done_d;

  logic [CH_W-1:0]    grant_ch;
  logic [CH_W-1:0]    cand;
  logic               grant_vld;
  logic [NUM_CH-1:0]  act_onehot;
  logic               act_req;
  logic               act_ack;
  logic               lookup_end;
  logic               timeout;

  // Round-robin pick: first requesting channel after the last one served
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(last_grant_q) + k) % NUM_CH);
      if (!grant_vld && bus.sprite_incoming[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
      end
    end
  end

  // Decode of the granted channel and its request/ack lines
  always_comb begin
    act_onehot = '0;
    act_onehot[active_ch_q] = 1'b1;
    act_req    = bus.sprite_incoming[active_ch_q];
    act_ack    = bus.acknowledge_finished_sprite[active_ch_q];
    lookup_end = (lat_cnt_q == LAT_END);
  end

`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_END = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q, err_d;

  // Watchdog: counts BLIT cycles; error latched on forced exit, dropped when DONE ends
  always_comb begin
    wd_cnt_d = (state_q == S_BLIT) ? wd_cnt_q + 1'b1 : '0;
    timeout  = (state_q == S_BLIT) && (wd_cnt_q == WD_END);
    err_d    = err_q;
    if ((state_q == S_BLIT) && !done_q && timeout) begin
      err_d = 1'b1;
    end else if ((state_q == S_DONE) && act_ack) begin
      err_d = 1'b0;
    end
  end

  // Watchdog registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign bus.blit_error = err_q;
`else
  assign timeout        = 1'b0;
  assign bus.blit_error = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (grant_vld)          state_d = S_LOOKUP;
      S_LOOKUP:  if (lookup_end)         state_d = S_START;
      S_START:                           state_d = S_RELEASE;
      S_RELEASE: if (!act_req)           state_d = S_BLIT;
      S_BLIT:    if (done_q || timeout)  state_d = S_DONE;
      S_DONE:    if (act_ack)            state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  // FSM outputs: strobes are decoded from state and steered to the granted channel
  always_comb begin
    bus.blitter_start   = (state_q == S_START);
    bus.sprite_received = ((state_q == S_START) || (state_q == S_RELEASE)) ? act_onehot : '0;
    bus.sprite_finished = (state_q == S_DONE) ? act_onehot : '0;
    bus.busy            = (state_q != S_IDLE);
  end

  // Transaction context: grant capture, table wait counter, result capture, done flag
  always_comb begin
    active_ch_d   = active_ch_q;
    last_grant_d  = last_grant_q;
    table_index_d = table_index_q;
    addr_d        = addr_q;
    xs_d          = xs_q;
    ys_d          = ys_q;
    lat_cnt_d     = '0;
    done_d        = done_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (grant_vld) begin
          active_ch_d   = grant_ch;
          table_index_d = bus.sprite_num[int'(grant_ch)*IDX_W +: IDX_W];
        end
      end
      S_LOOKUP: begin
        lat_cnt_d = lat_cnt_q + 1'b1;
        if (lookup_end) begin
          {addr_d, xs_d, ys_d} = bus.table_data;
          lat_cnt_d = '0;
        end
      end
      // blitter_finished may arrive as early as the start pulse itself
      S_START, S_RELEASE, S_BLIT: begin
        if (bus.blitter_finished) done_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b0;
        if (act_ack) last_grant_d = active_ch_q;
      end
      default: ;
    endcase
  end

  // Transaction context registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      active_ch_q   <= '0;
      last_grant_q  <= LAST_CH;
      table_index_q <= '0;
      addr_q        <= '0;
      xs_q          <= '0;
      ys_q          <= '0;
      lat_cnt_q     <= '0;
      done_q        <= 1'b0;
    end else begin
      active_ch_q   <= active_ch_d;
      last_grant_q  <= last_grant_d;
      table_index_q <= table_index_d;
      addr_q        <= addr_d;
      xs_q          <= xs_d;
      ys_q          <= ys_d;
      lat_cnt_q     <= lat_cnt_d;
      done_q        <= done_d;
    end
  end

  assign bus.table_index    = table_index_q;
  assign bus.sprite_address = addr_q;
  assign bus.x_size         = xs_q;
  assign bus.y_size         = ys_q;
  assign bus.active_ch      = active_ch_q;
endmodule

// File: tb/tb_sprite_dispatcher.sv
// Bench for sprite_dispatcher: directed timing sequences, a vector table of
// round-robin transactions, and randomized transactions checked against a
// transaction-level round-robin model. Define WATCHDOG_EN for the timeout case.
module tb_sprite_dispatcher;
  localparam int NUM_CH    = 4;
  localparam int IDX_W     = 6;
  localparam int ADDR_W    = 25;
  localparam int SIZE_W    = 10;
  localparam int TABLE_LAT = 1;
  localparam int TIMEOUT   = 16;
  localparam int DW        = ADDR_W + 2*SIZE_W;

  typedef struct {
    logic [NUM_CH-1:0] mask;
    int                exp_ch;
    int                fin_dly;
    bit                wrong_ack;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  sprite_dispatcher_if #(.NUM_CH(NUM_CH), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) bus ();

  sprite_dispatcher #(
    .NUM_CH(NUM_CH), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W),
    .TABLE_LAT(TABLE_LAT), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  // Sprite table model: one-cycle synchronous read
  logic [DW-1:0] mem [64];
  always @(posedge Clk) bus.table_data <= mem[bus.table_index];

  int n_chk = 0;
  int n_fail = 0;
  int start_cnt = 0;
  bit multi_hot = 1'b0;
  int last_model;
  logic [IDX_W-1:0] idx_v [NUM_CH];
  vec_t vecs [8];
  logic [NUM_CH-1:0] rmask;
  int s0;
  int cnt;
  bit ok;

  always @(posedge Clk) if (bus.blitter_start === 1'b1) start_cnt++;
  always @(negedge Clk)
    if ($countones(bus.sprite_received) > 1 || $countones(bus.sprite_finished) > 1) multi_hot = 1'b1;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idx();
    for (int c = 0; c < NUM_CH; c++) bus.sprite_num[c*IDX_W +: IDX_W] = idx_v[c];
  endtask

  task automatic new_idx();
    for (int c = 0; c < NUM_CH; c++) idx_v[c] = IDX_W'($urandom_range(0, 63));
    drive_idx();
  endtask

  task automatic recover();
    bus.sprite_incoming = '0;
    bus.acknowledge_finished_sprite = '0;
    bus.blitter_finished = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    last_model = NUM_CH - 1;
  endtask

  // Round-robin reference: requester with the smallest forward distance from the last grant
  function automatic int rr_pick(input logic [NUM_CH-1:0] m, input int last);
    int best;
    int best_d;
    int d;
    best = -1;
    best_d = NUM_CH + 1;
    for (int c = 0; c < NUM_CH; c++) begin
      d = (c - last - 1 + 2*NUM_CH) % NUM_CH;
      if (m[c] && d < best_d) begin
        best_d = d;
        best = c;
      end
    end
    return best;
  endfunction

  // From the START cycle: finish the blit, run the finish/ack handshake, check results
  task automatic complete_txn(input logic [NUM_CH-1:0] oh, input logic [DW-1:0] e,
                              input int fin_dly, input bit wrong_ack, input int s_base);
    bit fin_ok;
    if (fin_dly == 0) bus.blitter_finished = 1'b1;
    tick();
    bus.blitter_finished = 1'b0;
    bus.sprite_incoming = '0;
    new_idx();
    if (fin_dly > 0) begin
      repeat (fin_dly) tick();
      bus.blitter_finished = 1'b1;
      tick();
      bus.blitter_finished = 1'b0;
    end
    fin_ok = 1'b0;
    for (int t = 0; t < 20 && !fin_ok; t++) begin
      fin_ok = (bus.sprite_finished != '0);
      if (!fin_ok) tick();
    end
    if (!fin_ok) begin
      check("finish_wait_timeout", 64'(bus.sprite_finished), 64'(oh));
      recover();
      return;
    end
    check("finished_onehot", 64'(bus.sprite_finished), 64'(oh));
    check("blit_error_clear", 64'(bus.blit_error), 64'd0);
    check("data_held", {bus.sprite_address, bus.x_size, bus.y_size}, 64'(e));
    if (wrong_ack) begin
      bus.acknowledge_finished_sprite = ~oh;
      tick();
      check("foreign_ack_ignored", 64'(bus.sprite_finished), 64'(oh));
      bus.acknowledge_finished_sprite = '0;
    end
    bus.acknowledge_finished_sprite = oh;
    tick();
    bus.acknowledge_finished_sprite = '0;
    check("idle_after_ack", {bus.busy, bus.sprite_finished}, 64'd0);
    check("start_pulses", 64'(start_cnt - s_base), 64'd1);
  endtask

  task automatic run_txn(input logic [NUM_CH-1:0] mask, input int exp_ch,
                         input int fin_dly, input bit wrong_ack);
    logic [NUM_CH-1:0] oh;
    logic [DW-1:0] e;
    bit rx_ok;
    int sb;
    oh = '0;
    oh[exp_ch] = 1'b1;
    new_idx();
    sb = start_cnt;
    bus.sprite_incoming = mask;
    rx_ok = 1'b0;
    for (int t = 0; t < 20 && !rx_ok; t++) begin
      tick();
      rx_ok = (bus.sprite_received != '0);
    end
    if (!rx_ok) begin
      check("grant_wait_timeout", 64'(bus.sprite_received), 64'(oh));
      recover();
      return;
    end
    e = mem[idx_v[exp_ch]];
    check("grant_onehot", 64'(bus.sprite_received), 64'(oh));
    check("active_ch", 64'(bus.active_ch), 64'(exp_ch));
    check("start_with_received", 64'(bus.blitter_start), 64'd1);
    check("table_result", {bus.sprite_address, bus.x_size, bus.y_size}, 64'(e));
    complete_txn(oh, e, fin_dly, wrong_ack, sb);
    last_model = exp_ch;
  endtask

  initial begin
    vecs[0] = '{4'b1111, 1, 2, 1'b0};
    vecs[1] = '{4'b1111, 2, 0, 1'b0};
    vecs[2] = '{4'b1111, 3, 1, 1'b0};
    vecs[3] = '{4'b1111, 0, 3, 1'b0};
    vecs[4] = '{4'b0101, 2, 1, 1'b1};
    vecs[5] = '{4'b0011, 0, 2, 1'b0};
    vecs[6] = '{4'b1000, 3, 0, 1'b0};
    vecs[7] = '{4'b0010, 1, 4, 1'b1};

    for (int i = 0; i < 64; i++) mem[i] = DW'({$urandom, $urandom});
    mem[5] = {25'h1000, 10'd32, 10'd16};
    mem[7] = {25'h0abcde, 10'd100, 10'd200};

    bus.sprite_incoming = '0;
    bus.acknowledge_finished_sprite = '0;
    bus.blitter_finished = 1'b0;
    for (int c = 0; c < NUM_CH; c++) idx_v[c] = '0;
    drive_idx();
    Reset = 1'b1;
    last_model = NUM_CH - 1;
    tick();
    tick();
    check("reset_ctrl", {bus.sprite_received, bus.sprite_finished, bus.blitter_start,
                         bus.busy, bus.blit_error, bus.active_ch, bus.table_index}, 64'd0);
    check("reset_data", {bus.sprite_address, bus.x_size, bus.y_size}, 64'd0);
    Reset = 1'b0;
    tick();
    check("idle_no_req", 64'(bus.busy), 64'd0);

    // Single ch0 request, exact-cycle walk through the transaction
    idx_v[0] = 6'd5;
    drive_idx();
    s0 = start_cnt;
    bus.sprite_incoming = 4'b0001;
    tick();
    check("t1_busy", 64'(bus.busy), 64'd1);
    check("t1_table_index", 64'(bus.table_index), 64'd5);
    check("t1_no_rx_in_lookup", 64'(bus.sprite_received), 64'd0);
    tick();
    check("t1_no_start_early", 64'(bus.blitter_start), 64'd0);
    tick();
    check("t1_start", 64'(bus.blitter_start), 64'd1);
    check("t1_received", 64'(bus.sprite_received), 64'd1);
    check("t1_addr", 64'(bus.sprite_address), 64'h1000);
    check("t1_xsize", 64'(bus.x_size), 64'd32);
    check("t1_ysize", 64'(bus.y_size), 64'd16);
    bus.sprite_incoming = '0;
    tick();
    check("t1_start_one_cycle", 64'(bus.blitter_start), 64'd0);
    check("t1_received_release", 64'(bus.sprite_received), 64'd1);
    tick();
    check("t1_blit_no_rx", {bus.sprite_received, bus.busy}, 64'd1);
    tick();
    bus.blitter_finished = 1'b1;
    tick();
    bus.blitter_finished = 1'b0;
    check("t1_not_done_yet", 64'(bus.sprite_finished), 64'd0);
    tick();
    check("t1_finished", 64'(bus.sprite_finished), 64'd1);
    repeat (2) tick();
    check("t1_finished_held", 64'(bus.sprite_finished), 64'd1);
    bus.acknowledge_finished_sprite = 4'b0001;
    tick();
    bus.acknowledge_finished_sprite = '0;
    check("t1_idle", {bus.busy, bus.sprite_finished}, 64'd0);
    check("t1_start_count", 64'(start_cnt - s0), 64'd1);
    last_model = 0;

    // Round-robin vector table
    for (int i = 0; i < 8; i++) run_txn(vecs[i].mask, vecs[i].exp_ch, vecs[i].fin_dly, vecs[i].wrong_ack);

    // Reset during BLIT with ch0 request pending
    idx_v[0] = 6'd7;
    drive_idx();
    bus.sprite_incoming = 4'b0001;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      tick();
      ok = (bus.sprite_received != '0);
    end
    check("t5_grant", 64'(bus.sprite_received), 64'(4'b0001 << rr_pick(4'b0001, last_model)));
    bus.sprite_incoming = '0;
    tick();
    tick();
    check("t5_in_blit", {bus.busy, bus.sprite_received}, 64'h10);
    bus.sprite_incoming = 4'b0001;
    s0 = start_cnt;
    #2 Reset = 1'b1;
    #1;
    check("t5_reset_ctrl", {bus.sprite_received, bus.sprite_finished, bus.blitter_start,
                            bus.busy, bus.blit_error, bus.active_ch, bus.table_index}, 64'd0);
    check("t5_reset_data", {bus.sprite_address, bus.x_size, bus.y_size}, 64'd0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    last_model = NUM_CH - 1;
    check("t5_no_pulse", 64'(start_cnt - s0), 64'd0);
    tick();
    check("t5_regrant_lookup", {bus.busy, bus.table_index}, {57'd0, 1'b1, 6'd7});
    tick();
    tick();
    check("t5_start", {bus.blitter_start, bus.sprite_received}, 64'h11);
    check("t5_data", {bus.sprite_address, bus.x_size, bus.y_size}, 64'(mem[7]));
    complete_txn(4'b0001, mem[7], 1, 1'b0, s0);
    last_model = 0;

`ifdef WATCHDOG_EN
    // No blitter_finished: watchdog forces DONE after TIMEOUT BLIT cycles
    idx_v[1] = 6'd9;
    drive_idx();
    bus.sprite_incoming = 4'b0010;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      tick();
      ok = (bus.sprite_received != '0);
    end
    check("t6_grant", 64'(bus.sprite_received), 64'(4'b0010));
    bus.sprite_incoming = '0;
    cnt = 0;
    ok = 1'b0;
    for (int t = 0; t < 2*TIMEOUT + 10 && !ok; t++) begin
      tick();
      cnt++;
      ok = (bus.sprite_finished != '0);
    end
    check("t6_latency", 64'(cnt), 64'(2 + TIMEOUT));
    check("t6_error_with_finish", {bus.blit_error, bus.sprite_finished}, 64'h12);
    tick();
    check("t6_error_held", 64'(bus.blit_error), 64'd1);
    bus.acknowledge_finished_sprite = 4'b0010;
    tick();
    bus.acknowledge_finished_sprite = '0;
    check("t6_error_cleared", {bus.blit_error, bus.busy}, 64'd0);
    last_model = 1;
`endif

    // Randomized transactions against the round-robin model
    for (int i = 0; i < 40; i++) begin
      rmask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      run_txn(rmask, rr_pick(rmask, last_model), int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));
    end

    check("never_multi_hot", 64'(multi_hot), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
